// File: rtl/gfx256_pkg.sv
// Shared types and the round-robin search used by the gfx256 read arbiter.
package gfx256_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } arb_state_t;

    localparam int          RR_MAX    = 32;
    localparam int          RR_IW     = 5;
    localparam logic [31:0] SEL_RESET = 32'hFFFF_FFFF;

    // First requester at or after (last+1) mod n, wrapping; returns last when none is pending.
    function automatic int unsigned rr_next(input logic [RR_MAX-1:0] req,
                                            input int unsigned       last,
                                            input int unsigned       n);
        int unsigned idx;
        logic        found;
        rr_next = last;
        found   = 1'b0;
        for (int unsigned k = 1; k <= RR_MAX; k++) begin
            if (!found && (k <= n)) begin
                idx = last + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (req[idx[RR_IW-1:0]]) begin
                    rr_next = idx;
                    found   = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/gfx256_rr_pick.sv
// Combinational round-robin winner finder over NREQ request lines.
module gfx256_rr_pick
    import gfx256_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int GW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [GW-1:0]   last,
    output logic            valid,
    output logic [GW-1:0]   winner
);

    logic [RR_MAX-1:0] req_ext;

    always_comb begin
        req_ext             = '0;
        req_ext[NREQ-1:0]   = req;
        valid               = |req;
        winner              = GW'(rr_next(req_ext, 32'(last), $unsigned(NREQ)));
    end

endmodule

// File: rtl/gfx256_read_arbiter.sv
// Round-robin arbiter sharing one wishbone reader between the texture, blender and depth units.
module gfx256_read_arbiter
    import gfx256_pkg::*;
#(
    parameter int MDW  = 256,
    parameter int NREQ = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NREQ-1:0]   req_i,
    input  logic [32*NREQ-1:0] addr_i,
    input  logic [32*NREQ-1:0] sel_i,
    output logic [NREQ-1:0]   ack_o,
    output logic [MDW-1:0]    data_o,
    output logic [NREQ-1:0]   busy_o,
    input  logic              wbm_busy_i,
    output logic              m_request_o,
    output logic [31:0]       m_addr_o,
    output logic [31:0]       m_sel_o,
    input  logic              m_ack_i,
    input  logic [MDW-1:0]    m_data_i
);

    localparam int            GW         = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [GW-1:0] LAST_RESET = GW'(NREQ - 1);

    arb_state_t      state;
    arb_state_t      state_nxt;
    logic [GW-1:0]   grant;
    logic [GW-1:0]   last_grant;
    logic [GW-1:0]   pick;
    logic            pick_valid;
    logic            start;
    logic            finish;
    logic [NREQ-1:0] ack_onehot;

    gfx256_rr_pick #(
        .NREQ (NREQ),
        .GW   (GW)
    ) u_pick (
        .req    (req_i),
        .last   (last_grant),
        .valid  (pick_valid),
        .winner (pick)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // DONE is a one-cycle gap so a requester still holding req_i after its ack is not re-granted.
    always_comb begin
        state_nxt = ST_IDLE;
        start     = 1'b0;
        finish    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_valid && !wbm_busy_i) begin
                    start     = 1'b1;
                    state_nxt = ST_BUS;
                end
            end
            ST_BUS: begin
                if (m_ack_i) begin
                    finish    = 1'b1;
                    state_nxt = ST_DONE;
                end else begin
                    state_nxt = ST_BUS;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign ack_onehot = NREQ'(1) << grant;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            m_request_o <= 1'b0;
            m_addr_o    <= '0;
            m_sel_o     <= SEL_RESET;
            ack_o       <= '0;
            data_o      <= '0;
            grant       <= '0;
            last_grant  <= LAST_RESET;
        end else begin
            ack_o <= '0;
            if (start) begin
                grant       <= pick;
                m_request_o <= 1'b1;
                m_addr_o    <= addr_i[32*int'(pick) +: 32];
                m_sel_o     <= sel_i[32*int'(pick) +: 32];
            end
            if (finish) begin
                data_o      <= m_data_i;
                ack_o       <= ack_onehot;
                m_request_o <= 1'b0;
                last_grant  <= grant;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            busy_o[i] = (state != ST_IDLE) && (grant != GW'(i));
        end
    end

    ack_onehot0_a: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(ack_o));

endmodule

// File: tb/tb_gfx256_read_arbiter.sv
// Self-checking bench for gfx256_read_arbiter: directed scenarios plus a randomized run against a cycle model.
module tb_gfx256_read_arbiter;

    localparam int MDW  = 256;
    localparam int NREQ = 3;

    logic                 clk_i;
    logic                 rst_i;
    logic [NREQ-1:0]      req_i;
    logic [32*NREQ-1:0]   addr_i;
    logic [32*NREQ-1:0]   sel_i;
    logic [NREQ-1:0]      ack_o;
    logic [MDW-1:0]       data_o;
    logic [NREQ-1:0]      busy_o;
    logic                 wbm_busy_i;
    logic                 m_request_o;
    logic [31:0]          m_addr_o;
    logic [31:0]          m_sel_o;
    logic                 m_ack_i;
    logic [MDW-1:0]       m_data_i;

    int checks = 0;
    int errors = 0;

    gfx256_read_arbiter #(
        .MDW  (MDW),
        .NREQ (NREQ)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .addr_i      (addr_i),
        .sel_i       (sel_i),
        .ack_o       (ack_o),
        .data_o      (data_o),
        .busy_o      (busy_o),
        .wbm_busy_i  (wbm_busy_i),
        .m_request_o (m_request_o),
        .m_addr_o    (m_addr_o),
        .m_sel_o     (m_sel_o),
        .m_ack_i     (m_ack_i),
        .m_data_i    (m_data_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [MDW-1:0] rand_data();
        logic [MDW-1:0] r;
        for (int i = 0; i < MDW/32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic int rr_model(input logic [NREQ-1:0] r, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] s);
        addr_i[32*i +: 32] = a;
        sel_i[32*i +: 32]  = s;
    endtask

    task automatic do_reset();
        rst_i      = 1'b1;
        req_i      = '0;
        m_ack_i    = 1'b0;
        wbm_busy_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    // Requester-side handshake: waits for the bus request, acks after 'delay' cycles, drops the acked req.
    task automatic run_txn(input int delay,
                           output logic [31:0] a_seen, output logic [31:0] s_seen,
                           output logic [NREQ-1:0] ack_seen, output logic [NREQ-1:0] busy_seen,
                           output logic [MDW-1:0] d_seen, output logic [MDW-1:0] d_sent,
                           output bit to);
        int n = 0;
        to = 1'b0; a_seen = 'x; s_seen = 'x; ack_seen = 'x; busy_seen = 'x; d_seen = 'x; d_sent = '0;
        while (m_request_o !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (m_request_o !== 1'b1) begin
            to = 1'b1;
            return;
        end
        a_seen    = m_addr_o;
        s_seen    = m_sel_o;
        busy_seen = busy_o;
        repeat (delay) tick();
        d_sent   = rand_data();
        m_data_i = d_sent;
        m_ack_i  = 1'b1;
        tick();
        ack_seen = ack_o;
        d_seen   = data_o;
        m_ack_i  = 1'b0;
        req_i    = req_i & ~ack_o;
        tick();
    endtask

    task automatic test_reset();
        rst_i = 1'b1; req_i = '0; m_ack_i = 1'b0; wbm_busy_i = 1'b0;
        addr_i = '0; sel_i = '0; m_data_i = '0;
        tick();
        checks++; if (m_request_o !== 1'b0) begin errors++; $display("FAIL reset_m_request: got %b expected 0", m_request_o); end
        checks++; if (m_addr_o !== 32'h0) begin errors++; $display("FAIL reset_m_addr: got %h expected 0", m_addr_o); end
        checks++; if (m_sel_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_m_sel: got %h expected ffffffff", m_sel_o); end
        checks++; if (ack_o !== 3'b000) begin errors++; $display("FAIL reset_ack: got %b expected 000", ack_o); end
        checks++; if (data_o !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", data_o); end
        checks++; if (busy_o !== 3'b000) begin errors++; $display("FAIL reset_busy: got %b expected 000", busy_o); end
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_single();
        logic [31:0] a, s; logic [NREQ-1:0] ak, bz; logic [MDW-1:0] dv, ds; bit to;
        do_reset();
        set_req(1, 32'h0000_1000, 32'h0000_00F0);
        req_i = 3'b010;
        run_txn(4, a, s, ak, bz, dv, ds, to);
        checks++; if (to) begin errors++; $display("FAIL single_timeout: got no m_request_o expected one"); end
        checks++; if (a !== 32'h0000_1000) begin errors++; $display("FAIL single_addr: got %h expected 00001000", a); end
        checks++; if (s !== 32'h0000_00F0) begin errors++; $display("FAIL single_sel: got %h expected 000000f0", s); end
        checks++; if (bz !== 3'b101) begin errors++; $display("FAIL single_busy: got %b expected 101", bz); end
        checks++; if (ak !== 3'b010) begin errors++; $display("FAIL single_ack: got %b expected 010", ak); end
        checks++; if (dv !== ds) begin errors++; $display("FAIL single_data: got %h expected %h", dv, ds); end
        checks++; if (ack_o !== 3'b000) begin errors++; $display("FAIL single_ack_one_cycle: got %b expected 000", ack_o); end
        checks++; if (data_o !== ds) begin errors++; $display("FAIL single_data_hold: got %h expected %h", data_o, ds); end
        checks++; if (m_request_o !== 1'b0) begin errors++; $display("FAIL single_req_clear: got %b expected 0", m_request_o); end
    endtask

    task automatic test_contention();
        logic [31:0] a, s; logic [NREQ-1:0] ak, bz; logic [MDW-1:0] dv, ds; bit to;
        int order1 [3] = '{0, 1, 2};
        int order2 [3] = '{1, 2, 0};
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 32'hA000_0000 + 32'(i) * 32'h100, 32'h0F0F_0000 | 32'(i));
        req_i = 3'b111;
        for (int j = 0; j < 3; j++) begin
            run_txn($urandom_range(0, 3), a, s, ak, bz, dv, ds, to);
            checks++; if (ak !== (NREQ'(1) << order1[j])) begin errors++; $display("FAIL contention_burst1_%0d: got ack %b expected grant %0d", j, ak, order1[j]); end
            checks++; if (a !== 32'hA000_0000 + 32'(order1[j]) * 32'h100) begin errors++; $display("FAIL contention_addr1_%0d: got %h", j, a); end
        end
        req_i = 3'b001;
        run_txn(1, a, s, ak, bz, dv, ds, to);
        checks++; if (ak !== 3'b001) begin errors++; $display("FAIL contention_solo0: got %b expected 001", ak); end
        req_i = 3'b111;
        for (int j = 0; j < 3; j++) begin
            run_txn($urandom_range(0, 3), a, s, ak, bz, dv, ds, to);
            checks++; if (ak !== (NREQ'(1) << order2[j])) begin errors++; $display("FAIL contention_burst2_%0d: got ack %b expected grant %0d", j, ak, order2[j]); end
            checks++; if (dv !== ds) begin errors++; $display("FAIL contention_data2_%0d: got %h expected %h", j, dv, ds); end
        end
    endtask

    task automatic test_writer_block();
        int high_cycles = 0;
        do_reset();
        set_req(0, 32'h0000_2000, 32'hFFFF_FFFF);
        wbm_busy_i = 1'b1;
        req_i      = 3'b001;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (m_request_o !== 1'b0) high_cycles++;
        end
        checks++; if (high_cycles != 0) begin errors++; $display("FAIL writer_block: got %0d request cycles expected 0", high_cycles); end
        wbm_busy_i = 1'b0;
        tick();
        checks++; if (m_request_o !== 1'b1) begin errors++; $display("FAIL writer_release: got %b expected 1", m_request_o); end
        checks++; if (m_addr_o !== 32'h0000_2000) begin errors++; $display("FAIL writer_addr: got %h expected 00002000", m_addr_o); end
        m_data_i = rand_data();
        m_ack_i  = 1'b1;
        tick();
        m_ack_i = 1'b0;
        req_i   = '0;
        tick();
        tick();
    endtask

    task automatic test_held();
        logic [31:0] a, s; logic [NREQ-1:0] ak, bz; logic [MDW-1:0] dv, ds; bit to;
        int extra = 0;
        do_reset();
        set_req(1, 32'h0000_0111, 32'h1);
        req_i = 3'b010;
        run_txn(0, a, s, ak, bz, dv, ds, to);
        checks++; if (ak !== 3'b010) begin errors++; $display("FAIL held_prime: got %b expected 010", ak); end
        set_req(0, 32'h0000_0100, 32'h2);
        set_req(2, 32'h0000_0300, 32'h3);
        req_i = 3'b101;
        run_txn(2, a, s, ak, bz, dv, ds, to);
        checks++; if (ak !== 3'b100) begin errors++; $display("FAIL held_first: got %b expected 100", ak); end
        checks++; if (a !== 32'h0000_0300) begin errors++; $display("FAIL held_addr: got %h expected 00000300", a); end
        run_txn(1, a, s, ak, bz, dv, ds, to);
        checks++; if (ak !== 3'b001) begin errors++; $display("FAIL held_next: got %b expected 001", ak); end
        req_i = 3'b100;
        run_txn(0, a, s, ak, bz, dv, ds, to);
        checks++; if (ak !== 3'b100) begin errors++; $display("FAIL held_solo: got %b expected 100", ak); end
        for (int i = 0; i < 8; i++) begin
            if (m_request_o !== 1'b0) extra++;
            tick();
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL held_double_serve: got %0d request cycles expected 0", extra); end
    endtask

    task automatic test_reset_mid_bus();
        logic [31:0] a, s; logic [NREQ-1:0] ak, bz; logic [MDW-1:0] dv, ds; bit to;
        int n = 0;
        do_reset();
        set_req(0, 32'h0000_0040, 32'hF);
        req_i = 3'b001;
        run_txn(0, a, s, ak, bz, dv, ds, to);
        set_req(1, 32'h0000_0080, 32'hF0);
        req_i = 3'b010;
        while (m_request_o !== 1'b1 && n < 20) begin tick(); n++; end
        checks++; if (m_request_o !== 1'b1) begin errors++; $display("FAIL rstbus_setup: got %b expected 1", m_request_o); end
        tick();
        rst_i = 1'b1;
        req_i = '0;
        tick();
        rst_i = 1'b0;
        checks++; if (m_request_o !== 1'b0) begin errors++; $display("FAIL rstbus_req: got %b expected 0", m_request_o); end
        checks++; if (data_o !== '0) begin errors++; $display("FAIL rstbus_data: got %h expected 0", data_o); end
        tick();
        m_data_i = '1;
        m_ack_i  = 1'b1;
        tick();
        m_ack_i = 1'b0;
        checks++; if (ack_o !== 3'b000) begin errors++; $display("FAIL rstbus_late_ack: got %b expected 000", ack_o); end
        checks++; if (data_o !== '0) begin errors++; $display("FAIL rstbus_late_data: got %h expected 0", data_o); end
        tick();
        checks++; if (ack_o !== 3'b000 || m_request_o !== 1'b0) begin errors++; $display("FAIL rstbus_quiet: got ack %b req %b expected 000 0", ack_o, m_request_o); end
    endtask

    task automatic test_spurious_ack();
        logic [31:0] a, s; logic [NREQ-1:0] ak, bz; logic [MDW-1:0] dv, ds; bit to;
        do_reset();
        set_req(2, 32'h0000_0C00, 32'hFF);
        req_i = 3'b100;
        run_txn(3, a, s, ak, bz, dv, ds, to);
        m_data_i = '1;
        m_ack_i  = 1'b1;
        tick();
        m_ack_i = 1'b0;
        checks++; if (ack_o !== 3'b000) begin errors++; $display("FAIL spurious_ack: got %b expected 000", ack_o); end
        checks++; if (data_o !== ds) begin errors++; $display("FAIL spurious_data: got %h expected %h", data_o, ds); end
        tick();
        checks++; if (data_o !== ds || ack_o !== 3'b000) begin errors++; $display("FAIL spurious_after: got %h ack %b expected %h 000", data_o, ack_o, ds); end
    endtask

    task automatic test_random();
        int phase = 0, last = NREQ - 1, win = 0;
        logic [NREQ-1:0] a_req, exp_ack, exp_busy;
        logic a_busy, a_ack;
        logic [MDW-1:0] a_data, exp_data;
        logic [32*NREQ-1:0] a_addr, a_sel;
        logic [31:0] exp_addr, exp_sel;
        do_reset();
        exp_data = '0; exp_addr = '0; exp_sel = '1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            a_req = req_i; a_busy = wbm_busy_i; a_ack = m_ack_i; a_data = m_data_i;
            a_addr = addr_i; a_sel = sel_i;
            tick();
            exp_ack = '0;
            case (phase)
                0: if (a_req != '0 && !a_busy) begin
                       win      = rr_model(a_req, last);
                       exp_addr = a_addr[32*win +: 32];
                       exp_sel  = a_sel[32*win +: 32];
                       phase    = 1;
                   end
                1: if (a_ack) begin
                       exp_data = a_data;
                       exp_ack  = NREQ'(1) << win;
                       last     = win;
                       phase    = 2;
                   end
                default: phase = 0;
            endcase
            exp_busy = (phase != 0) ? ~(NREQ'(1) << win) : '0;
            checks++; if (m_request_o !== (phase == 1)) begin errors++; $display("FAIL rand_req cyc %0d: got %b expected %b", cyc, m_request_o, phase == 1); end
            checks++; if (ack_o !== exp_ack) begin errors++; $display("FAIL rand_ack cyc %0d: got %b expected %b", cyc, ack_o, exp_ack); end
            checks++; if (data_o !== exp_data) begin errors++; $display("FAIL rand_data cyc %0d: got %h expected %h", cyc, data_o, exp_data); end
            checks++; if (busy_o !== exp_busy) begin errors++; $display("FAIL rand_busy cyc %0d: got %b expected %b", cyc, busy_o, exp_busy); end
            if (phase == 1) begin
                checks++; if (m_addr_o !== exp_addr || m_sel_o !== exp_sel) begin errors++; $display("FAIL rand_addr cyc %0d: got %h/%h expected %h/%h", cyc, m_addr_o, m_sel_o, exp_addr, exp_sel); end
            end
            req_i = req_i & ~exp_ack;
            for (int i = 0; i < NREQ; i++) begin
                if (!req_i[i] && $urandom_range(0, 3) == 0) begin
                    req_i[i] = 1'b1;
                    set_req(i, $urandom, $urandom);
                end
            end
            if (phase == 1 && $urandom_range(0, 19) == 0) req_i[win] = 1'b0;
            wbm_busy_i = ($urandom_range(0, 4) == 0);
            m_ack_i    = (phase == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            m_data_i   = rand_data();
        end
        req_i = '0; m_ack_i = 1'b0; wbm_busy_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_writer_block();
        test_held();
        test_reset_mid_bus();
        test_spurious_ack();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
